// File: rtl/dsp_mailbox_xfer.sv
// Frame-based PL<->DSP mailbox: snapshots a word vector into the write DPBRAM, reads a
// block back from the read DPBRAM through a latency-matched index pipe, then publishes it.
module dsp_mailbox_xfer #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int N_WR    = 48,
  parameter int N_RD    = 12,
  parameter int WR_BASE = 0,
  parameter int RD_BASE = 0,
  parameter int RD_LAT  = 2,
  parameter int PERIOD  = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_trig,
  input  logic [N_WR*DATA_W-1:0]   i_wr_vec,
  output logic [ADDR_W-1:0]        o_w_ram_addr,
  output logic [DATA_W-1:0]        o_w_ram_din,
  output logic                     o_w_ram_we,
  output logic [ADDR_W-1:0]        o_r_ram_addr,
  output logic                     o_r_ram_en,
  input  logic [DATA_W-1:0]        i_r_ram_dout,
  output logic [N_RD*DATA_W-1:0]   o_rd_vec,
  output logic                     o_rd_valid,
  output logic                     o_busy,
  output logic                     o_overrun,
  output logic [15:0]              o_frame_cnt
);

  localparam int N_MAX = (N_WR > N_RD) ? N_WR : N_RD;
  localparam int IDX_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam logic [IDX_W-1:0] WR_LAST = IDX_W'(N_WR - 1);
  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(N_RD - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SNAP   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;

  generate
    if (N_WR < 1 || N_RD < 1 || RD_LAT < 1) begin : g_bad_params
      $error("dsp_mailbox_xfer: N_WR, N_RD and RD_LAT must all be >= 1");
    end
    if (WR_BASE + N_WR > (1 << ADDR_W)) begin : g_bad_wr_window
      $error("dsp_mailbox_xfer: write window exceeds the DPBRAM address space");
    end
    if (RD_BASE + N_RD > (1 << ADDR_W)) begin : g_bad_rd_window
      $error("dsp_mailbox_xfer: read window exceeds the DPBRAM address space");
    end
  endgenerate

  logic [2:0]             state_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [N_WR*DATA_W-1:0] snap_reg;
  logic [N_RD*DATA_W-1:0] shadow;
  logic [N_RD*DATA_W-1:0] rd_vec_reg;
  logic                   rd_valid_reg;
  logic [15:0]            frame_cnt_reg;
  logic [RD_LAT-1:0]      pipe_v_reg;
  logic [IDX_W-1:0]       pipe_idx_reg [RD_LAT];

  logic tick;
  logic start;
  logic busy;
  logic wr_strobe;
  logic rd_strobe;
  logic last_ret;

  // Free-running period timer; it keeps counting during frames so ticks stay on the grid.
  generate
    if (PERIOD > 0) begin : g_timer
      localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
      logic [TMR_W-1:0] timer_reg;

      assign tick = i_en && (timer_reg == TMR_W'(PERIOD - 1));

      always_ff @(posedge i_clk) begin
        if (i_rst || !i_en || tick) begin
          timer_reg <= '0;
        end else begin
          timer_reg <= timer_reg + 1'b1;
        end
      end
    end else begin : g_no_timer
      assign tick = 1'b0;
    end
  endgenerate

  assign start     = i_en && (i_trig || tick);
  assign busy      = (state_reg != S_IDLE);
  assign wr_strobe = (state_reg == S_WRITE);
  assign rd_strobe = (state_reg == S_READ);
  assign last_ret  = pipe_v_reg[RD_LAT-1] && (pipe_idx_reg[RD_LAT-1] == RD_LAST);

  assign o_busy       = busy;
  assign o_overrun    = start && busy && !i_rst;
  assign o_w_ram_we   = wr_strobe;
  assign o_r_ram_en   = rd_strobe;
  assign o_w_ram_addr = wr_strobe ? (ADDR_W'(WR_BASE) + ADDR_W'(idx_reg)) : '0;
  assign o_r_ram_addr = rd_strobe ? (ADDR_W'(RD_BASE) + ADDR_W'(idx_reg)) : '0;
  assign o_rd_vec     = rd_vec_reg;
  assign o_rd_valid   = rd_valid_reg;
  assign o_frame_cnt  = frame_cnt_reg;

  always_comb begin
    o_w_ram_din = '0;
    for (int k = 0; k < N_WR; k++) begin
      if (wr_strobe && idx_reg == IDX_W'(k)) begin
        o_w_ram_din = snap_reg[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      snap_reg      <= '0;
      rd_vec_reg    <= '0;
      rd_valid_reg  <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      rd_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_SNAP;
          end
        end
        S_SNAP: begin
          snap_reg  <= i_wr_vec;
          idx_reg   <= '0;
          state_reg <= S_WRITE;
        end
        S_WRITE: begin
          if (idx_reg == WR_LAST) begin
            idx_reg   <= '0;
            state_reg <= S_READ;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_READ: begin
          if (idx_reg == RD_LAST) begin
            idx_reg   <= '0;
            state_reg <= S_DRAIN;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_DRAIN: begin
          if (last_ret) begin
            state_reg <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          rd_vec_reg    <= shadow;
          rd_valid_reg  <= 1'b1;
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
          state_reg     <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Read index travels alongside the RAM latency so each returning word knows its slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pipe_v_reg <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_idx_reg[k] <= '0;
      end
    end else begin
      pipe_v_reg[0]   <= rd_strobe;
      pipe_idx_reg[0] <= idx_reg;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_v_reg[k]   <= pipe_v_reg[k-1];
        pipe_idx_reg[k] <= pipe_idx_reg[k-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_RD; gi++) begin : g_shadow
      logic [DATA_W-1:0] word_reg;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          word_reg <= '0;
        end else if (pipe_v_reg[RD_LAT-1] && pipe_idx_reg[RD_LAT-1] == IDX_W'(gi)) begin
          word_reg <= i_r_ram_dout;
        end
      end

      assign shadow[gi*DATA_W +: DATA_W] = word_reg;
    end
  endgenerate

endmodule
